// File: rtl/uart_tx_periph.sv
// Bus-mapped UART transmitter: TX FIFO feeding an 8N1 serializer with a programmable divisor.
// Define UART_TX_IRQ_EN to add the CTRL register (offset 4) and the irq output.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter logic [15:0] DIVISOR_RESET = 16'd434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       wrt_en,
    input  logic       chip_select,
`ifdef UART_TX_IRQ_EN
    output logic       irq,
`endif
    output logic       tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic [7:0]    dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          wr_cyc, rd_cyc;
    logic          push_req, push_ok, pop;
    logic          fifo_empty, fifo_full, busy, baud_done;
    logic [15:0]   reload;
    logic [7:0]    status;

`ifdef UART_TX_IRQ_EN
    logic ctrl_q, ctrl_d;
    logic irq_q, irq_d;
`endif

    always_comb begin
        wr_cyc     = chip_select & wrt_en;
        rd_cyc     = chip_select & ~wrt_en;
        push_req   = wr_cyc && (address == 3'd0);
        push_ok    = push_req && (count_q < DEPTH_C);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        busy       = (state_q != IDLE);
        baud_done  = (baud_q == 16'd0);
        // A divisor of zero still yields a one-cycle bit period
        reload     = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
        status     = {4'd0, ovf_q, busy, fifo_empty, fifo_full};
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = reload;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = reload;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = reload;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        baud_d  = reload;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        div_d = div_q;
        if (wr_cyc && address == 3'd2) div_d[7:0] = data_in;
        if (wr_cyc && address == 3'd3) div_d[15:8] = data_in;

        // Set beats the read-clear when both land on the same edge
        ovf_d = ovf_q;
        if (rd_cyc && address == 3'd1) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;

        dout_d = dout_q;
        if (rd_cyc) begin
            unique case (address)
                3'd1:    dout_d = status;
                3'd2:    dout_d = div_q[7:0];
                3'd3:    dout_d = div_q[15:8];
`ifdef UART_TX_IRQ_EN
                3'd4:    dout_d = {7'd0, ctrl_q};
`endif
                default: dout_d = 8'h00;
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_cyc && address == 3'd4) ctrl_d = data_in[0];
        irq_d = ctrl_q & fifo_empty & ~busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            div_q   <= DIVISOR_RESET;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            dout_q  <= 8'h00;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign tx       = tx_q;
    assign data_out = dout_q;

endmodule
